// File: rtl/prog_fetch.sv
// Program-descriptor fetcher: takes a program number, runs the two-half
// ro_data_mem read and holds the complete loop/APU constant set as one descriptor.
//
// state   | meaning
// IDLE    | no request held, ready to accept
// ISSUE   | mem_reset_read pulse, read address presented
// HALF0   | memory loading low halves
// HALF1   | memory loading high halves
// CAPTURE | memory outputs complete, copied into descriptor on exit
// VALID   | descriptor held until consumer takes it
module prog_fetch #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int LOOP_CNT      = 4,
  parameter int APU_CNT       = 4,
  parameter int LOOP_W        = LOOP_CNT*2*ADDRESS_WIDTH,
  parameter int APU_W         = APU_CNT*(LOOP_CNT*2+1)*3*ADDRESS_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_prog_addr,
  output logic              mem_reset_read,
  output logic [7:0]        mem_read_addr,
  input  logic [LOOP_W-1:0] mem_loop_data,
  input  logic [APU_W-1:0]  mem_apu_data,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [7:0]        desc_prog_addr,
  output logic              desc_null,
  output logic [LOOP_W-1:0] desc_loop_data,
  output logic [APU_W-1:0]  desc_apu_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_HALF0, S_HALF1, S_CAPTURE, S_VALID
  } state_t;

  state_t state, state_nxt;
  logic   accept, accept_null, accept_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    if (!abort)
      req_ready = (state == S_IDLE) || ((state == S_VALID) && desc_ready);
    accept       = req_valid && req_ready;
    accept_null  = accept && (req_prog_addr == 8'd0);
    accept_fetch = accept && (req_prog_addr != 8'd0);

    case (state)
      S_IDLE: begin
        if (accept_null)       state_nxt = S_VALID;
        else if (accept_fetch) state_nxt = S_ISSUE;
      end
      S_ISSUE:   state_nxt = S_HALF0;
      S_HALF0:   state_nxt = S_HALF1;
      S_HALF1:   state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_VALID;
      S_VALID: begin
        // retiring descriptor can be replaced by the next request in the same cycle
        if (desc_ready) begin
          if (accept_null)       state_nxt = S_VALID;
          else if (accept_fetch) state_nxt = S_ISSUE;
          else                   state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase

    if (abort) state_nxt = S_IDLE;
  end

  assign mem_reset_read = (state == S_ISSUE);
  assign desc_valid     = (state == S_VALID);

  // Descriptor fields change only as a whole: on null accept or on leaving CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_addr  <= 8'd0;
      desc_prog_addr <= 8'd0;
      desc_null      <= 1'b0;
      desc_loop_data <= '0;
      desc_apu_data  <= '0;
    end else if (abort) begin
      desc_null <= 1'b0;
    end else if (accept_null) begin
      desc_null      <= 1'b1;
      desc_prog_addr <= 8'd0;
      desc_loop_data <= '0;
      desc_apu_data  <= '0;
    end else if (accept_fetch) begin
      mem_read_addr <= req_prog_addr;
    end else if (state == S_CAPTURE) begin
      desc_null      <= 1'b0;
      desc_prog_addr <= mem_read_addr;
      desc_loop_data <= mem_loop_data;
      desc_apu_data  <= mem_apu_data;
    end
  end

endmodule
